// File: rtl/tdm_demux_rx.sv
// TDM receive demultiplexer: locks to the slot-0 frame marker and steers
// each beat into its channel's valid/ready holding register.
module tdm_demux_rx #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [W-1:0]    in_data,
  output logic [N_CH-1:0] ch_valid,
  output logic [N_CH*W-1:0] ch_data,
  input  logic [N_CH-1:0] ch_ready,
  output logic            locked,
  output logic            sync_err,
  output logic [N_CH-1:0] ovf
);

  localparam int SW = $clog2(N_CH);
  localparam logic [SW-1:0] LAST = SW'(N_CH - 1);
  localparam logic [SW-1:0] ONE  = SW'(1);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_slot;
  logic [SW-1:0]   w_slot_nxt;
  logic            w_wr;
  logic [SW-1:0]   w_wr_ch;
  logic            w_serr;
  logic [N_CH-1:0] w_hit;
  logic            r_serr;
  logic [N_CH-1:0] r_valid;
  logic [N_CH-1:0] r_ovf;
  logic [W-1:0]    r_data [N_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_slot  <= '0;
      r_serr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_serr  <= w_serr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_wr        = 1'b0;
    w_wr_ch     = '0;
    w_serr      = 1'b0;
    if (in_valid) begin
      unique case (r_state)
        HUNT: begin
          if (in_sof) begin
            w_wr        = 1'b1;
            w_slot_nxt  = ONE;
            w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          unique case (1'b1)
            in_sof: begin
              // An early marker resyncs instead of dropping lock.
              w_wr       = 1'b1;
              w_slot_nxt = ONE;
              w_serr     = (r_slot != '0);
            end
            (!in_sof && r_slot == '0): begin
              w_serr      = 1'b1;
              w_slot_nxt  = '0;
              w_state_nxt = HUNT;
            end
            (!in_sof && r_slot != '0): begin
              w_wr       = 1'b1;
              w_wr_ch    = r_slot;
              w_slot_nxt = (r_slot == LAST) ? '0 : r_slot + ONE;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_hit[i] = w_wr && (w_wr_ch == SW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_ovf   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        r_ovf[i] <= 1'b0;
        if (w_hit[i]) begin
          r_data[i]  <= in_data;
          r_valid[i] <= 1'b1;
          r_ovf[i]   <= r_valid[i] & ~ch_ready[i];
        end else if (r_valid[i] && ch_ready[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    ch_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_data[i*W +: W] = r_data[i];
    end
  end

  assign ch_valid = r_valid;
  assign ovf      = r_ovf;
  assign sync_err = r_serr;
  assign locked   = (r_state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Self-checking bench for tdm_demux_rx: directed scenarios plus a
// randomized run against a frame-level reference model.
module tb_tdm_demux_rx;

  localparam int N_CH = 4;
  localparam int W    = 8;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_sof;
  logic [W-1:0]    in_data;
  logic [N_CH-1:0] ch_valid;
  logic [N_CH*W-1:0] ch_data;
  logic [N_CH-1:0] ch_ready;
  logic            locked;
  logic            sync_err;
  logic [N_CH-1:0] ovf;

  int n_checks;
  int n_fail;

  bit              m_locked;
  int              m_slot;
  logic [W-1:0]    m_data [N_CH];
  logic [N_CH-1:0] m_valid;
  logic [N_CH-1:0] m_ovf;
  logic            m_serr;

  tdm_demux_rx #(.N_CH(N_CH), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_data  (in_data),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .locked   (locked),
    .sync_err (sync_err),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_locked = 0;
    m_slot   = 0;
    m_valid  = '0;
    m_ovf    = '0;
    m_serr   = 1'b0;
    for (int i = 0; i < N_CH; i++) m_data[i] = '0;
  endtask

  function automatic logic [N_CH*W-1:0] m_pack();
    logic [N_CH*W-1:0] p;
    for (int i = 0; i < N_CH; i++) p[i*W +: W] = m_data[i];
    return p;
  endfunction

  // Drive one cycle, advance the reference model, sample 1ns after the edge.
  task automatic step(input logic v, input logic sof,
                      input logic [W-1:0] d, input logic [N_CH-1:0] rdy);
    bit wr;
    int ch;
    in_valid = v;
    in_sof   = sof;
    in_data  = d;
    ch_ready = rdy;
    @(posedge clk);
    wr = 0;
    ch = 0;
    m_serr = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (sof) begin
          wr = 1; m_locked = 1; m_slot = 1;
        end
      end else if (sof) begin
        m_serr = (m_slot != 0);
        wr = 1; m_slot = 1;
      end else if (m_slot == 0) begin
        m_serr = 1'b1; m_locked = 0;
      end else begin
        wr = 1; ch = m_slot; m_slot = (m_slot + 1) % N_CH;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      m_ovf[i] = 1'b0;
      if (wr && ch == i) begin
        m_ovf[i]   = m_valid[i] && !rdy[i];
        m_valid[i] = 1'b1;
        m_data[i]  = d;
      end else if (m_valid[i] && rdy[i]) begin
        m_valid[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; in_sof = 0; in_data = '0; ch_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++; $display("FAIL reset_locked: got %b want 0", locked);
    end
    n_checks++;
    if (ch_valid !== '0 || ch_data !== '0) begin
      n_fail++; $display("FAIL reset_ch: got %h/%h want 0/0", ch_valid, ch_data);
    end
    n_checks++;
    if (sync_err !== 1'b0 || ovf !== '0) begin
      n_fail++; $display("FAIL reset_err: got %b/%b want 0/0", sync_err, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pre_sof_drop();
    step(1, 0, 8'h11, '1);
    step(1, 0, 8'h22, '1);
    n_checks++;
    if (locked !== 1'b0 || ch_valid !== '0) begin
      n_fail++; $display("FAIL drop: locked %b valid %b want 0 0", locked, ch_valid);
    end
  endtask

  task automatic test_frames();
    logic [W-1:0] e;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N_CH; i++) begin
        e = (f == 0) ? (8'hA0 + 8'(i)) : (8'hB0 + 8'(i));
        step(1, i == 0, e, '1);
        n_checks++;
        if (ch_valid[i] !== 1'b1 || ch_data[i*W +: W] !== e) begin
          n_fail++;
          $display("FAIL frame_ch%0d: got %b/%h want 1/%h", i, ch_valid[i], ch_data[i*W +: W], e);
        end
        n_checks++;
        if (locked !== 1'b1 || sync_err !== 1'b0 || ovf !== '0) begin
          n_fail++;
          $display("FAIL frame_flags: got %b/%b/%b want 1/0/0", locked, sync_err, ovf);
        end
      end
    end
  endtask

  task automatic test_early_sof();
    step(1, 1, 8'h01, '1);
    step(1, 0, 8'h02, '1);
    step(1, 1, 8'h5A, '1);
    n_checks++;
    if (sync_err !== 1'b1 || ch_data[7:0] !== 8'h5A || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL early_sof: got serr %b ch0 %h lk %b want 1 5a 1", sync_err, ch_data[7:0], locked);
    end
    step(1, 0, 8'h66, '1);
    n_checks++;
    if (sync_err !== 1'b0 || ch_valid[1] !== 1'b1 || ch_data[15:8] !== 8'h66) begin
      n_fail++;
      $display("FAIL early_next: got serr %b v1 %b ch1 %h want 0 1 66", sync_err, ch_valid[1], ch_data[15:8]);
    end
    step(1, 0, 8'h77, '1);
    step(1, 0, 8'h88, '1);
  endtask

  task automatic test_missing_sof();
    step(1, 0, 8'h33, '1);
    n_checks++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || ch_valid !== '0) begin
      n_fail++;
      $display("FAIL missing_sof: got serr %b lk %b v %b want 1 0 0", sync_err, locked, ch_valid);
    end
    step(1, 0, 8'h44, '1);
    n_checks++;
    if (sync_err !== 1'b0 || locked !== 1'b0 || ch_valid !== '0) begin
      n_fail++;
      $display("FAIL hunt_drop: got serr %b lk %b v %b want 0 0 0", sync_err, locked, ch_valid);
    end
    step(1, 1, 8'h55, '1);
    n_checks++;
    if (locked !== 1'b1 || ch_data[7:0] !== 8'h55 || ch_valid[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL relock: got lk %b ch0 %h want 1 55", locked, ch_data[7:0]);
    end
    for (int i = 1; i < N_CH; i++) step(1, 0, 8'(i), '1);
  endtask

  task automatic test_overrun();
    logic [N_CH-1:0] rdy;
    rdy = 4'b1101;
    step(1, 1, 8'h00, rdy);
    step(1, 0, 8'h10, rdy);
    n_checks++;
    if (ovf !== '0 || ch_valid[1] !== 1'b1) begin
      n_fail++; $display("FAIL ovr_first: got ovf %b v1 %b want 0 1", ovf, ch_valid[1]);
    end
    step(1, 0, 8'h02, rdy);
    step(1, 0, 8'h03, rdy);
    step(1, 1, 8'h00, rdy);
    step(1, 0, 8'h20, rdy);
    n_checks++;
    if (ovf !== 4'b0010 || ch_data[15:8] !== 8'h20 || ch_valid[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_second: got ovf %b ch1 %h want 0010 20", ovf, ch_data[15:8]);
    end
    step(0, 0, 8'hFF, rdy);
    n_checks++;
    if (ovf !== '0 || ch_valid[1] !== 1'b1 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_idle: got ovf %b v1 %b lk %b want 0 1 1", ovf, ch_valid[1], locked);
    end
    step(1, 0, 8'h02, rdy);
    step(1, 0, 8'h03, rdy);
    step(1, 1, 8'h00, rdy);
    step(1, 0, 8'h30, 4'b1111);
    n_checks++;
    if (ovf !== '0 || ch_valid[1] !== 1'b1 || ch_data[15:8] !== 8'h30) begin
      n_fail++;
      $display("FAIL ovr_wr_consume: got ovf %b v1 %b ch1 %h want 0 1 30", ovf, ch_valid[1], ch_data[15:8]);
    end
    step(0, 0, 8'h00, '1);
    n_checks++;
    if (ch_valid[1] !== 1'b0) begin
      n_fail++; $display("FAIL ovr_drain: got v1 %b want 0", ch_valid[1]);
    end
    step(1, 0, 8'h02, '1);
    step(1, 0, 8'h03, '1);
  endtask

  task automatic test_async_reset();
    step(1, 1, 8'hC0, '0);
    step(1, 0, 8'hC1, '0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (locked !== 1'b0 || ch_valid !== '0 || ch_data !== '0) begin
      n_fail++;
      $display("FAIL async_rst: got lk %b v %b d %h want 0 0 0", locked, ch_valid, ch_data);
    end
    n_checks++;
    if (sync_err !== 1'b0 || ovf !== '0) begin
      n_fail++; $display("FAIL async_rst_err: got %b/%b want 0/0", sync_err, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1, 0, 8'hC2, '1);
    n_checks++;
    if (locked !== 1'b0 || ch_valid !== '0) begin
      n_fail++; $display("FAIL post_rst_hunt: got lk %b v %b want 0 0", locked, ch_valid);
    end
    step(1, 1, 8'hC3, '1);
    n_checks++;
    if (locked !== 1'b1 || ch_data[7:0] !== 8'hC3) begin
      n_fail++; $display("FAIL post_rst_lock: got lk %b ch0 %h want 1 c3", locked, ch_data[7:0]);
    end
  endtask

  task automatic test_random();
    logic v, sof;
    for (int n = 0; n < 400; n++) begin
      v = ($urandom % 4) != 0;
      if (m_locked) sof = (m_slot == 0) ? (($urandom % 8) != 0) : (($urandom % 12) == 0);
      else sof = ($urandom % 3) == 0;
      step(v, sof, W'($urandom), N_CH'($urandom));
      n_checks++;
      if (ch_valid !== m_valid || ch_data !== m_pack()) begin
        n_fail++;
        $display("FAIL rnd_ch @%0d: got %b/%h want %b/%h", n, ch_valid, ch_data, m_valid, m_pack());
      end
      n_checks++;
      if (locked !== m_locked || sync_err !== m_serr || ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL rnd_flags @%0d: got %b/%b/%b want %b/%b/%b", n, locked, sync_err, ovf, m_locked, m_serr, m_ovf);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_pre_sof_drop();
    test_frames();
    test_early_sof();
    test_missing_sof();
    test_overrun();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
